// File: rtl/siso_frame_pkg.sv
// siso_frame_pkg
//   Shared types and helpers for the single-bit serial frame receiver.
//   - rx_state_t     : receiver FSM state encoding
//   - DEFAULT_DATA_W : default number of data bits per frame
//   - MAX_DATA_W     : widest supported frame payload
//   - even_parity()  : XOR reduction of a zero-extended data word
package siso_frame_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int MAX_DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic even_parity(input logic [MAX_DATA_W-1:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/siso_rx_shifter.sv
// siso_rx_shifter
//   Data-bit shift register and bit counter for the frame receiver.
//   Bits enter at the LSB, so the first (MSB) bit ends up on top.
// Ports:
//   clk      : clock
//   reset    : asynchronous active-low reset
//   clear    : synchronous clear of shift register and counter
//   shift_en : shift bit_in in and advance the counter
//   bit_in   : serial bit to shift in
//   shift_q  : current shift register contents
//   done     : counter is at the last data bit (DATA_W-1)
module siso_rx_shifter
  import siso_frame_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] shift_q,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] shift_r;
  logic [CNT_W-1:0]  cnt_r;

  // Shift register and saturating bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (clear) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (shift_en) begin
      shift_r <= {shift_r[DATA_W-2:0], bit_in};
      // Hold at the last index rather than wrapping.
      if (cnt_r != LAST_CNT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign shift_q = shift_r;
  assign done    = (cnt_r == LAST_CNT);

endmodule

// File: rtl/siso_frame_rx.sv
// siso_frame_rx
//   Deframes a 1-bit-per-clock serial stream: start bit (~IDLE_LVL),
//   DATA_W data bits MSB first, optional even-parity bit, stop bit
//   (IDLE_LVL). Received words are offered on a valid/ready port.
//   Optional feature macro: SISO_FRAME_RX_PARITY_EN (adds PARITY state
//   and the parity_err output).
// Ports:
//   clk        : clock, serial_in sampled on every rising edge
//   reset      : asynchronous active-low reset
//   serial_in  : serial line
//   data_out   : received word, stable while data_valid=1
//   data_valid : word available, held until accepted
//   data_ready : consumer accept
//   frame_err  : one-cycle pulse on a bad stop bit
//   overrun    : sticky, a good frame was dropped while data_valid=1
//   busy       : frame in progress
//   parity_err : (parity build only) one-cycle pulse on bad parity
module siso_frame_rx
  import siso_frame_pkg::*;
#(
  parameter int   DATA_W   = DEFAULT_DATA_W,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
`ifdef SISO_FRAME_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  rx_state_t         state_r, state_nxt_s;
  logic              clear_s, shift_en_s, done_s;
  logic [DATA_W-1:0] shift_q_s;
  logic              stop_ok_s, par_ok_s;

  logic [DATA_W-1:0] data_out_r, data_out_nxt_s;
  logic              data_valid_r, data_valid_nxt_s;
  logic              frame_err_r, frame_err_nxt_s;
  logic              overrun_r, overrun_nxt_s;
  logic              busy_r;

  siso_rx_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_s),
    .shift_en (shift_en_s),
    .bit_in   (serial_in),
    .shift_q  (shift_q_s),
    .done     (done_s)
  );

  assign stop_ok_s = (serial_in == IDLE_LVL);

`ifdef SISO_FRAME_RX_PARITY_EN
  logic parity_bit_r;
  logic parity_err_r, parity_err_nxt_s;

  // Captures the parity bit while the FSM sits in PARITY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_bit_r <= 1'b0;
    end else if (state_r == PARITY) begin
      parity_bit_r <= serial_in;
    end
  end

  assign par_ok_s = ((even_parity(MAX_DATA_W'(shift_q_s)) ^ parity_bit_r) == 1'b0);
`else
  assign par_ok_s = 1'b1;
`endif

  // Next-state logic and shifter control.
  always_comb begin
    state_nxt_s = state_r;
    clear_s     = 1'b0;
    shift_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // Keep the shifter clean so an aborted frame leaves nothing behind.
        clear_s = 1'b1;
        if (serial_in == ~IDLE_LVL) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        shift_en_s = 1'b1;
        if (done_s) begin
`ifdef SISO_FRAME_RX_PARITY_EN
          state_nxt_s = PARITY;
`else
          state_nxt_s = STOP;
`endif
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
`ifdef SISO_FRAME_RX_PARITY_EN
        state_nxt_s = STOP;
`else
        state_nxt_s = IDLE;
`endif
      end
      STOP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output-register next values: word store, handshake, error flags.
  always_comb begin
    data_out_nxt_s   = data_out_r;
    // An accept frees the slot; data_ready means nothing while valid is low.
    data_valid_nxt_s = data_valid_r & ~data_ready;
    frame_err_nxt_s  = 1'b0;
    overrun_nxt_s    = overrun_r;
`ifdef SISO_FRAME_RX_PARITY_EN
    parity_err_nxt_s = 1'b0;
`endif
    if (state_r == STOP) begin
      if (!stop_ok_s) begin
        frame_err_nxt_s = 1'b1;
      end else begin
        frame_err_nxt_s = 1'b0;
      end
`ifdef SISO_FRAME_RX_PARITY_EN
      if (!par_ok_s) begin
        parity_err_nxt_s = 1'b1;
      end else begin
        parity_err_nxt_s = 1'b0;
      end
`endif
      if (stop_ok_s && par_ok_s) begin
        // Slot is free if empty or being accepted on this same edge.
        if (!data_valid_r || data_ready) begin
          data_out_nxt_s   = shift_q_s;
          data_valid_nxt_s = 1'b1;
        end else begin
          overrun_nxt_s = 1'b1;
        end
      end else begin
        data_out_nxt_s = data_out_r;
      end
    end else begin
      frame_err_nxt_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
`ifdef SISO_FRAME_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt_s;
      data_out_r   <= data_out_nxt_s;
      data_valid_r <= data_valid_nxt_s;
      frame_err_r  <= frame_err_nxt_s;
      overrun_r    <= overrun_nxt_s;
      busy_r       <= (state_nxt_s != IDLE);
`ifdef SISO_FRAME_RX_PARITY_EN
      parity_err_r <= parity_err_nxt_s;
`endif
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;
`ifdef SISO_FRAME_RX_PARITY_EN
  assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_siso_frame_rx.sv
// tb_siso_frame_rx
//   Directed self-checking bench for siso_frame_rx (DATA_W=8, IDLE_LVL=0).
//   Parity cases are included when SISO_FRAME_RX_PARITY_EN is defined.
module tb_siso_frame_rx;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              serial_in = 1'b0;
  logic              data_ready = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              frame_err;
  logic              overrun;
  logic              busy;
`ifdef SISO_FRAME_RX_PARITY_EN
  logic              parity_err;
  logic              par_flip = 1'b0;
`endif

  int   errors = 0;
  int   checks = 0;
  logic busy_seen = 1'b0;

  siso_frame_rx #(.DATA_W(DATA_W), .IDLE_LVL(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
`ifdef SISO_FRAME_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    tick();
  endtask

  // Start bit, data MSB first, [parity], stop bit; line returns to idle.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop_b, input logic rdy_on_stop);
    send_bit(1'b1);
    busy_seen = busy;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      send_bit(d[i]);
    end
`ifdef SISO_FRAME_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    data_ready = rdy_on_stop;
    send_bit(stop_b);
    data_ready = 1'b0;
    serial_in  = 1'b0;
  endtask

  initial begin
    // Reset held with a toggling line
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_bit(i[0]);
    end
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    serial_in = 1'b0;
    reset = 1'b1;
    tick(); tick(); tick();
    check("idle_busy", 32'(busy), 32'h0);

    // Single good frame 0xA5, hold then accept
    send_frame(8'hA5, 1'b0, 1'b0);
    check("a5_busy_mid", 32'(busy_seen), 32'h1);
    check("a5_valid", 32'(data_valid), 32'h1);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_frame_err", 32'(frame_err), 32'h0);
    check("a5_busy_end", 32'(busy), 32'h0);
    tick(); tick();
    check("a5_hold_valid", 32'(data_valid), 32'h1);
    check("a5_hold_data", 32'(data_out), 32'hA5);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("a5_accept_valid", 32'(data_valid), 32'h0);

    // Bad stop bit on 0x3C
    send_frame(8'h3C, 1'b1, 1'b0);
    check("bad_stop_frame_err", 32'(frame_err), 32'h1);
    check("bad_stop_valid", 32'(data_valid), 32'h0);
    check("bad_stop_busy", 32'(busy), 32'h0);
    tick();
    check("bad_stop_pulse_end", 32'(frame_err), 32'h0);
    check("bad_stop_idle", 32'(busy), 32'h0);

    // Accept and new store on the same edge: 0x33 then 0x44
    send_frame(8'h33, 1'b0, 1'b0);
    check("s33_data", 32'(data_out), 32'h33);
    send_frame(8'h44, 1'b0, 1'b1);
    check("s44_valid", 32'(data_valid), 32'h1);
    check("s44_data", 32'(data_out), 32'h44);
    check("s44_no_overrun", 32'(overrun), 32'h0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("s44_accept", 32'(data_valid), 32'h0);

    // Overrun: 0x11 and 0x22 back-to-back, nobody accepting
    send_frame(8'h11, 1'b0, 1'b0);
    check("o11_overrun", 32'(overrun), 32'h0);
    send_frame(8'h22, 1'b0, 1'b0);
    check("o22_data", 32'(data_out), 32'h11);
    check("o22_valid", 32'(data_valid), 32'h1);
    check("o22_overrun", 32'(overrun), 32'h1);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("o_accept_valid", 32'(data_valid), 32'h0);
    check("o_sticky", 32'(overrun), 32'h1);

    // Reset after four data bits, then a clean 0x5A
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1);
    end
    reset = 1'b0;
    #2;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    check("mid_rst_data", 32'(data_out), 32'h0);
    serial_in = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(data_valid), 32'h0);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("r5a_valid", 32'(data_valid), 32'h1);
    check("r5a_data", 32'(data_out), 32'h5A);
    check("r5a_frame_err", 32'(frame_err), 32'h0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("r5a_accept", 32'(data_valid), 32'h0);

`ifdef SISO_FRAME_RX_PARITY_EN
    // 0x07 needs parity bit 1; flipping it sends 0
    par_flip = 1'b1;
    send_frame(8'h07, 1'b0, 1'b0);
    check("p_bad_parity_err", 32'(parity_err), 32'h1);
    check("p_bad_valid", 32'(data_valid), 32'h0);
    check("p_bad_frame_err", 32'(frame_err), 32'h0);
    tick();
    check("p_bad_pulse_end", 32'(parity_err), 32'h0);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b0, 1'b0);
    check("p_good_parity_err", 32'(parity_err), 32'h0);
    check("p_good_valid", 32'(data_valid), 32'h1);
    check("p_good_data", 32'(data_out), 32'h07);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    check("p_both_parity_err", 32'(parity_err), 32'h1);
    check("p_both_frame_err", 32'(frame_err), 32'h1);
    check("p_both_valid", 32'(data_valid), 32'h0);
    par_flip = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/siso_frame_rx.md
Name: siso_frame_rx

Overview:
- Receiving end of the team's single-bit serial links: deframes a 1-bit-per-clock serial stream into parallel words.
- Hunts for a start bit, shifts in DATA_W data bits MSB-first and checks the stop bit.
- Presents each word on a valid/ready output port, with overrun and framing-error reporting.
- Sits downstream of a serial shift/transmit chain, feeding parallel consumers (register files, FIFOs).

Parameters:
- DATA_W, 8, data bits per frame; legal range 2..32.
- IDLE_LVL, 0, line idle level; start bit is ~IDLE_LVL, stop bit is IDLE_LVL.

Ports:
- clk  input  1  single clock; serial_in is sampled on every rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- serial_in  input  1  serial line, one bit per clk, synchronous to clk.
- data_out  output  DATA_W  received word; stable while data_valid=1.
- data_valid  output  1  word available; held until accepted.
- data_ready  input  1  consumer accepts data_out when data_valid & data_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled != IDLE_LVL.
- overrun  output  1  sticky; a completed frame was dropped because data_valid was still high.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit counter=0.
- Reset values of all outputs: data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
- Reset mid-frame aborts the frame; no partial word is ever presented.
- FSM states: IDLE, DATA, [PARITY], STOP.
- IDLE: when serial_in==~IDLE_LVL, go to DATA; bit counter=0. Otherwise stay.
- DATA: each cycle shift serial_in into the LSB (MSB received first). Counter increments.
- DATA exit: after DATA_W bits (counter==DATA_W-1), go to PARITY if enabled, else STOP.
- STOP: sample serial_in.
  - If ==IDLE_LVL and data_valid==0: load data_out from the shift register; assert data_valid next edge.
  - If ==IDLE_LVL and data_valid==1: drop the word, set overrun. data_out is not overwritten.
  - If !=IDLE_LVL: pulse frame_err for one cycle; discard the word; data_valid unchanged.
  - Always return to IDLE.
- Frame length: 1+DATA_W+1 cycles without parity, +1 with parity. Back-to-back frames are legal; the start bit may directly follow the stop bit.
- Latency: data_valid rises on the edge that samples the stop bit, i.e. visible the cycle after the stop bit is on the line.
- Handshake:
  - data_valid deasserts the cycle after a data_valid&data_ready handshake.
  - data_ready is ignored when data_valid=0.
- Simultaneous accept and new store in the same STOP cycle: the accept frees the slot, so the new word loads. data_valid stays 1. No overrun.
- overrun is cleared only by reset.
- The counter uses $clog2(DATA_W) bits; no wrap beyond DATA_W-1.
- busy=1 in DATA/PARITY/STOP.

Optional Feature:
- Macro: SISO_FRAME_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted after the data bits; it samples one even-parity bit (XOR of data bits + parity == 0).
  - Adds output parity_err (1 bit), pulsed for one cycle in the STOP cycle of a frame with bad parity.
  - Word with bad parity is discarded like a framing error. If both the parity and the stop bit are bad, both pulses fire.
- Undefined: no PARITY state, no parity_err port; frames carry no parity bit.

Decomposition:
- Package siso_frame_pkg:
  - rx_state_t enum (IDLE, DATA, PARITY, STOP).
  - Function for even parity over a DATA_W vector.
  - Localparam for the default DATA_W.
- One natural sub-module: siso_rx_shifter. It holds the DATA_W shift register plus the bit counter, with shift_en/clear inputs and a done flag; the top keeps the FSM and handshake.

Test Plan:
- Reset: hold reset=0 with serial_in toggling -> all outputs 0. Release -> busy stays 0 while the line is at idle 0.
- Single frame, DATA_W=8: line 1, 1010_0101, 0 -> data_out=8'hA5, data_valid rises the cycle after the stop bit and holds until data_ready=1, then drops.
- Bad stop, DATA_W=8: frame 0x3C with stop bit 1 -> frame_err pulses one cycle; data_valid stays 0; FSM returns to IDLE.
- Overrun, data_ready=0, DATA_W=8: frames 0x11 then 0x22 back-to-back -> data_out=0x11, overrun=1. Then data_ready=1 -> 0x11 accepted.
- Reset mid-frame: assert reset after 4 data bits; release and send 0x5A -> only 0x5A is presented, no stale bits.
- With SISO_FRAME_RX_PARITY_EN: frame 0x07 with parity bit 0 -> parity_err pulse, no data_valid. Same frame with parity 1 -> data_out=0x07.
